// File: rtl/mim_rd_rsp.sv
// Memory read response path: credit-limited request acceptance, fixed-latency
// tag/valid pipeline alongside the memory, and an in-order response FIFO.
module mim_rd_rsp #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 64,
    parameter int TAG_W  = 8,
    parameter int RD_LAT = 2,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rd_req_valid,
    output logic                       rd_req_ready,
    input  logic [ADDR_W-1:0]          rd_req_addr,
    input  logic [TAG_W-1:0]           rd_req_tag,
    output logic                       mem_rd_en,
    output logic [ADDR_W-1:0]          mem_rd_addr,
    input  logic [DATA_W-1:0]          mem_rd_data,
    output logic                       rd_rsp_valid,
    input  logic                       rd_rsp_ready,
    output logic [DATA_W-1:0]          rd_rsp_data,
    output logic [TAG_W-1:0]           rd_rsp_tag,
    output logic [$clog2(DEPTH+1)-1:0] outstanding
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

    logic [CW-1:0]     cnt;
    logic [CW-1:0]     fifo_cnt;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [DATA_W-1:0] fifo_data [DEPTH];
    logic [TAG_W-1:0]  fifo_tag  [DEPTH];
    logic              vld_p     [RD_LAT];
    logic [TAG_W-1:0]  tag_p     [RD_LAT];
    logic              accept;
    logic              retire;
    logic              wr_en;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == LAST_C) ? '0 : ptr + 1'b1;
    endfunction

    // Credit gate: the FIFO can never hold more than DEPTH responses because
    // no more than DEPTH requests are ever in flight.
    assign rd_req_ready = !rst && (cnt < DEPTH_C);
    assign accept       = rd_req_valid && rd_req_ready;
    assign mem_rd_en    = accept;
    assign mem_rd_addr  = rd_req_addr;

    assign wr_en        = vld_p[RD_LAT-1];
    assign rd_rsp_valid = (fifo_cnt != '0);
    assign retire       = rd_rsp_valid && rd_rsp_ready;
    assign rd_rsp_data  = rd_rsp_valid ? fifo_data[rd_ptr] : '0;
    assign rd_rsp_tag   = rd_rsp_valid ? fifo_tag[rd_ptr]  : '0;
    assign outstanding  = cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            fifo_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            for (int i = 0; i < RD_LAT; i++) vld_p[i] <= 1'b0;
        end else begin
            case ({accept, retire})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            case ({wr_en, retire})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (wr_en)  wr_ptr <= next_ptr(wr_ptr);
            if (retire) rd_ptr <= next_ptr(rd_ptr);
            // stage boundary: request accept -> memory latency stages
            vld_p[0] <= accept;
            for (int i = 1; i < RD_LAT; i++) vld_p[i] <= vld_p[i-1];
        end
    end

    // Tag and FIFO payload carry no reset; their valid bits are authoritative.
    always_ff @(posedge clk) begin
        tag_p[0] <= rd_req_tag;
        for (int i = 1; i < RD_LAT; i++) tag_p[i] <= tag_p[i-1];
        // stage boundary: last latency stage -> response FIFO
        if (wr_en) begin
            fifo_data[wr_ptr] <= mem_rd_data;
            fifo_tag[wr_ptr]  <= tag_p[RD_LAT-1];
        end
    end

endmodule

// File: tb/tb_mim_rd_rsp.sv
// Directed bench for mim_rd_rsp with RD_LAT=2, DEPTH=4 and a two-cycle
// memory model whose data is a fixed function of the read address.
module tb_mim_rd_rsp;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 64;
    localparam int TAG_W  = 8;
    localparam int RD_LAT = 2;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              rd_req_valid;
    logic              rd_req_ready;
    logic [ADDR_W-1:0] rd_req_addr;
    logic [TAG_W-1:0]  rd_req_tag;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [DATA_W-1:0] mem_rd_data;
    logic              rd_rsp_valid;
    logic              rd_rsp_ready;
    logic [DATA_W-1:0] rd_rsp_data;
    logic [TAG_W-1:0]  rd_rsp_tag;
    logic [2:0]        outstanding;

    logic [DATA_W-1:0] d1, d2;
    logic              ovr_en = 1'b0;
    logic [DATA_W-1:0] ovr_val = '0;

    int checks = 0;
    int errors = 0;

    mim_rd_rsp #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W),
        .RD_LAT(RD_LAT), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
        .rd_req_addr(rd_req_addr), .rd_req_tag(rd_req_tag),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data),
        .rd_rsp_valid(rd_rsp_valid), .rd_rsp_ready(rd_rsp_ready),
        .rd_rsp_data(rd_rsp_data), .rd_rsp_tag(rd_rsp_tag),
        .outstanding(outstanding)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] f(input logic [ADDR_W-1:0] a);
        return (a == 20'h00010) ? 64'h0000_0000_DEAD_BEEF
                                : (64'h1000_0000_0000_0000 | {44'h0, a});
    endfunction

    // Memory returns f(addr) exactly two cycles after the read strobe.
    always @(posedge clk) begin
        d1 <= mem_rd_en ? f(mem_rd_addr) : '0;
        d2 <= d1;
    end
    assign mem_rd_data = ovr_en ? ovr_val : d2;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic v, input logic [7:0] t);
        rd_req_valid = v;
        rd_req_tag   = t;
        rd_req_addr  = {12'h0, t};
    endtask

    initial begin
        rst = 1'b1;
        rd_rsp_ready = 1'b1;
        req(1'b1, 8'h05);
        #2;
        chk("rst_ready", rd_req_ready, 0);
        chk("rst_mem_en", mem_rd_en, 0);
        chk("rst_rsp_valid", rd_rsp_valid, 0);
        chk("rst_rsp_data", rd_rsp_data, 0);
        chk("rst_rsp_tag", rd_rsp_tag, 0);
        chk("rst_outstanding", outstanding, 0);
        tick(); tick();
        rst = 1'b0;
        req(1'b0, 8'h00);
        #1;
        chk("post_rst_ready", rd_req_ready, 1);
        tick();

        // single request
        rd_rsp_ready = 1'b0;
        rd_req_valid = 1'b1; rd_req_addr = 20'h00010; rd_req_tag = 8'h05;
        #1;
        chk("t1_mem_en", mem_rd_en, 1);
        chk("t1_mem_addr", mem_rd_addr, 20'h00010);
        tick();
        rd_req_valid = 1'b0;
        #1;
        chk("t1_out_c1", outstanding, 1);
        chk("t1_valid_c1", rd_rsp_valid, 0);
        tick();
        #1;
        chk("t1_valid_c2", rd_rsp_valid, 0);
        tick();
        rd_rsp_ready = 1'b1;
        #1;
        chk("t1_valid_c3", rd_rsp_valid, 1);
        chk("t1_data", rd_rsp_data, 64'hDEAD_BEEF);
        chk("t1_tag", rd_rsp_tag, 8'h05);
        chk("t1_out_c3", outstanding, 1);
        tick();
        rd_rsp_ready = 1'b0;
        #1;
        chk("t1_out_c4", outstanding, 0);
        chk("t1_valid_c4", rd_rsp_valid, 0);
        tick();

        // back-to-back streaming
        rd_rsp_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            req(c < 4, 8'(c + 1));
            #1;
            if (c < 4) chk("t2_ready", rd_req_ready, 1);
            if (c >= 3 && c <= 6) begin
                chk("t2_valid", rd_rsp_valid, 1);
                chk("t2_tag", rd_rsp_tag, 64'(c - 2));
                chk("t2_data", rd_rsp_data, f(20'(c - 2)));
            end
            tick();
        end
        #1;
        chk("t2_out_end", outstanding, 0);
        tick();

        // credit exhaustion and drain
        rd_rsp_ready = 1'b0;
        for (int c = 0; c < 7; c++) begin
            req(1'b1, (c < 4) ? 8'(c + 1) : 8'd5);
            #1;
            chk("t3_ready", rd_req_ready, (c < 4) ? 1 : 0);
            tick();
        end
        rd_rsp_ready = 1'b1;
        #1;
        chk("t3_out_full", outstanding, 4);
        chk("t3_ready_full", rd_req_ready, 0);
        chk("t3_tag1", rd_rsp_tag, 1);
        chk("t3_data1", rd_rsp_data, f(20'd1));
        tick();
        #1;
        chk("t3_out_c8", outstanding, 3);
        chk("t3_ready_c8", rd_req_ready, 1);
        chk("t3_accept5", mem_rd_en, 1);
        chk("t3_tag2", rd_rsp_tag, 2);
        tick();
        req(1'b0, 8'h00);
        #1;
        chk("t3_out_c9", outstanding, 3);
        chk("t3_tag3", rd_rsp_tag, 3);
        tick();
        #1;
        chk("t3_tag4", rd_rsp_tag, 4);
        tick();
        #1;
        chk("t3_tag5", rd_rsp_tag, 5);
        chk("t3_data5", rd_rsp_data, f(20'd5));
        tick();
        #1;
        chk("t3_out_end", outstanding, 0);
        chk("t3_valid_end", rd_rsp_valid, 0);
        tick();

        // simultaneous accept and retire
        rd_rsp_ready = 1'b0;
        req(1'b1, 8'h11); tick();
        req(1'b1, 8'h12); tick();
        req(1'b0, 8'h00); tick();
        tick();
        req(1'b1, 8'h13);
        rd_rsp_ready = 1'b1;
        #1;
        chk("t4_out_c4", outstanding, 2);
        chk("t4_accept", mem_rd_en, 1);
        chk("t4_tag11", rd_rsp_tag, 8'h11);
        tick();
        req(1'b0, 8'h00);
        #1;
        chk("t4_out_c5", outstanding, 2);
        chk("t4_tag12", rd_rsp_tag, 8'h12);
        tick();
        #1;
        chk("t4_out_c6", outstanding, 1);
        chk("t4_valid_c6", rd_rsp_valid, 0);
        tick();
        #1;
        chk("t4_tag13", rd_rsp_tag, 8'h13);
        chk("t4_data13", rd_rsp_data, f(20'h13));
        tick();
        rd_rsp_ready = 1'b0;
        #1;
        chk("t4_out_end", outstanding, 0);
        tick();

        // full FIFO, single retire, then refill
        for (int c = 0; c < 6; c++) begin
            req(1'b1, (c < 4) ? 8'(8'h41 + c) : 8'h45);
            tick();
        end
        rd_rsp_ready = 1'b1;
        #1;
        chk("t5_ready_full", rd_req_ready, 0);
        chk("t5_out_full", outstanding, 4);
        chk("t5_tag41", rd_rsp_tag, 8'h41);
        tick();
        rd_rsp_ready = 1'b0;
        #1;
        chk("t5_out_c7", outstanding, 3);
        chk("t5_ready_c7", rd_req_ready, 1);
        chk("t5_accept45", mem_rd_en, 1);
        tick();
        req(1'b0, 8'h00);
        #1;
        chk("t5_out_c8", outstanding, 4);
        chk("t5_hold_tag", rd_rsp_tag, 8'h42);
        chk("t5_hold_data", rd_rsp_data, f(20'h42));
        tick();
        tick();
        rd_rsp_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("t5_drain_tag", rd_rsp_tag, 64'(8'h42 + c));
            chk("t5_drain_data", rd_rsp_data, f(20'(8'h42 + c)));
            tick();
        end
        #1;
        chk("t5_out_end", outstanding, 0);
        chk("t5_valid_end", rd_rsp_valid, 0);
        rd_rsp_ready = 1'b0;
        tick();

        // reset with requests in flight
        req(1'b1, 8'h61); tick();
        req(1'b1, 8'h62); tick();
        req(1'b1, 8'h63); tick();
        #1;
        chk("t6_pre_valid", rd_rsp_valid, 1);
        chk("t6_pre_out", outstanding, 3);
        req(1'b1, 8'h64);
        rst = 1'b1;
        #1;
        chk("t6_rst_ready", rd_req_ready, 0);
        chk("t6_rst_mem_en", mem_rd_en, 0);
        chk("t6_rst_valid", rd_rsp_valid, 0);
        chk("t6_rst_data", rd_rsp_data, 0);
        chk("t6_rst_tag", rd_rsp_tag, 0);
        chk("t6_rst_out", outstanding, 0);
        tick();
        req(1'b0, 8'h00);
        rst = 1'b0;
        ovr_en = 1'b1;
        rd_rsp_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            ovr_val = {$urandom, $urandom};
            #1;
            if (c == 0) chk("t6_ready_after", rd_req_ready, 1);
            chk("t6_no_valid", rd_rsp_valid, 0);
            chk("t6_out_zero", outstanding, 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mim_rd_rsp.md
MIM_RD_RSP -- requirements
Module: mim_rd_rsp

Interface
REQ-001 SHALL have parameter ADDR_W, default 20, meaning read address width.
REQ-002 SHALL have parameter DATA_W, default 64, meaning read data width.
REQ-003 SHALL have parameter TAG_W, default 8, meaning requester tag width.
REQ-004 SHALL have parameter RD_LAT, default 2, meaning fixed memory read latency in cycles (range 1..4).
REQ-005 SHALL have parameter DEPTH, default 4, meaning response buffer entries and outstanding-credit limit.
REQ-006 SHALL use one clock and an asynchronous, active-high reset.
REQ-007 clk  input  1  sole clock; all state on rising edge.
REQ-008 rst  input  1  asynchronous active-high reset.
REQ-009 rd_req_valid  input  1  read request present.
REQ-010 rd_req_ready  output  1  request accepted when valid&ready.
REQ-011 rd_req_addr  input  ADDR_W  read address.
REQ-012 rd_req_tag  input  TAG_W  requester tag, returned unchanged.
REQ-013 mem_rd_en  output  1  memory read strobe.
REQ-014 mem_rd_addr  output  ADDR_W  memory read address.
REQ-015 mem_rd_data  input  DATA_W  memory data, valid exactly RD_LAT cycles after mem_rd_en.
REQ-016 rd_rsp_valid  output  1  response present.
REQ-017 rd_rsp_ready  input  1  response consumed when valid&ready.
REQ-018 rd_rsp_data  output  DATA_W  read data.
REQ-019 rd_rsp_tag  output  TAG_W  tag of the request.
REQ-020 outstanding  output  $clog2(DEPTH+1)  accepted-but-not-retired count.

Function
REQ-021 Accept = rd_req_valid & rd_req_ready; mem_rd_en SHALL equal accept combinationally, mem_rd_addr = rd_req_addr.
REQ-022 rd_req_ready SHALL be (outstanding < DEPTH), registered-count-based, independent of rd_req_valid.
REQ-023 outstanding SHALL +1 on accept only, -1 on response handshake only, hold on both or neither; never exceeds DEPTH, never underflows.
REQ-024 Tag and a valid bit SHALL travel an RD_LAT-stage shift pipeline; at stage RD_LAT, mem_rd_data and tag SHALL be written into the response FIFO that cycle.
REQ-025 Response FIFO SHALL be DEPTH entries, in-order, wrap-around pointers; credit rule (REQ-022) guarantees no overflow, no drop.
REQ-026 Minimum latency: request accepted in cycle t -> rd_rsp_valid high in cycle t+RD_LAT+1.
REQ-027 Throughput SHALL be one request and one response per cycle sustained with rd_rsp_ready=1.
REQ-028 rd_rsp_valid = FIFO non-empty; rd_rsp_data/tag SHALL be held stable while valid & !ready.
REQ-029 Simultaneous FIFO write and read SHALL succeed at any occupancy, including full (read frees entry same cycle) and empty (no bypass; data appears next cycle).
REQ-030 Responses SHALL leave in acceptance order; tags are never reordered or altered.

Reset
REQ-031 While rst=1: rd_req_ready=0, mem_rd_en=0, rd_rsp_valid=0, rd_rsp_data=0, rd_rsp_tag=0, outstanding=0, immediately (asynchronous).
REQ-032 Reset mid-operation SHALL discard all in-flight pipeline and FIFO contents; mem_rd_data returning after reset release SHALL be ignored.
REQ-033 First cycle after rst deasserts: rd_req_ready=1.

Verification (RD_LAT=2, DEPTH=4)
REQ-034 Single req addr 0x00010 tag 0x05 at cycle 0, mem_rd_data=0xDEADBEEF at cycle 2 -> mem_rd_en=1 cycle 0, rd_rsp_valid cycle 3 with data 0xDEADBEEF tag 0x05; outstanding 1 then 0 after handshake.
REQ-035 Four back-to-back reqs tags 1..4, rd_rsp_ready=1 -> responses tags 1,2,3,4 in cycles 3..6, rd_req_ready stays 1.
REQ-036 rd_rsp_ready=0, six reqs offered -> tags 1..4 accepted, rd_req_ready=0 from cycle 4, outstanding=4; raise ready -> tags 1..4 drain in order, rd_req_ready=1 the cycle after first retire, tag 5 accepted then.
REQ-037 outstanding=2, accept and response handshake same cycle -> outstanding stays 2, FIFO order preserved.
REQ-038 Assert rst with 3 requests in flight -> all outputs 0 immediately; after release, toggling mem_rd_data produces no rd_rsp_valid, outstanding=0.
REQ-039 Full FIFO (4 entries, rd_rsp_ready=1 one cycle) -> one retire, outstanding 3, next request accepted following cycle, no loss.
